// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, constants and GF(2^8) helpers
// Purpose: common typedefs, the controller FSM enum, the S-box lookup and
// the GF(2^8) multiply-by-2 used by MixColumns. No ports (package).
package aes_pkg;

  typedef logic [127:0] aes_state_t;
  typedef logic [7:0]   aes_byte_t;

  localparam int AES_NR_128 = 10;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} ctrl_state_e;

  // S-box with entry 0x00 in the top byte, 0xff in the bottom byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry x sits at bit offset 8*(255-x); ~x is 255-x for an 8-bit x.
  function automatic aes_byte_t sbox(input aes_byte_t x);
    return SBOX_TBL[{~x, 3'b000} +: 8];
  endfunction

  // Multiply by 2 in GF(2^8), reduction polynomial 0x11b.
  function automatic aes_byte_t xtime(input aes_byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_round.sv
// rtl/aes_round.sv - one combinational AES encryption round
// Purpose: SubBytes -> ShiftRows -> MixColumns (skipped when last) -> AddRoundKey.
// Ports: state_in  - current state
//        round_key - key for this round
//        last      - final round, bypasses MixColumns
//        state_out - next state
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         last,
  output logic [127:0] state_out
);

  logic [127:0] sub;
  logic [127:0] sr;
  logic [127:0] mix;

  for (genvar i = 0; i < 16; i++) begin : g_sub
    assign sub[8*i +: 8] = sbox(state_in[8*i +: 8]);
  end

  shiftrows u_shiftrows (
    .din  (sub),
    .dout (sr)
  );

  for (genvar c = 0; c < 4; c++) begin : g_mix
    aes_byte_t a0, a1, a2, a3;
    aes_byte_t m0, m1, m2, m3;

    assign a0 = sr[127-32*c -: 8];
    assign a1 = sr[119-32*c -: 8];
    assign a2 = sr[111-32*c -: 8];
    assign a3 = sr[103-32*c -: 8];

    // 3*a is written as xtime(a) ^ a.
    assign m0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign m1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign m2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign m3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);

    assign mix[127-32*c -: 32] = last ? {a0, a1, a2, a3} : {m0, m1, m2, m3};
  end

  assign state_out = mix ^ round_key;

endmodule

// File: rtl/shiftrows.sv
// rtl/shiftrows.sv - AES ShiftRows byte permutation
// Purpose: rotates row r of the column-major state left by r bytes.
// Ports: din  - state in, [127:120] is byte s0
//        dout - permuted state, same byte order
module shiftrows (
  input  logic [127:0] din,
  output logic [127:0] dout
);

  // Byte index 4*c+r; output (r,c) takes input (r,(c+r)%4).
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign dout[127-8*(4*c+r) -: 8] = din[127-8*(4*((c+r)%4)+r) -: 8];
    end
  end

endmodule

// File: rtl/aes_enc_ctrl.sv
// rtl/aes_enc_ctrl.sv - iterative AES encryption controller
// Purpose: holds the state register and round counter, stepping one round per
// cycle through aes_round; round keys are fetched externally via rk_idx.
// Ports: clk, rst_n                      - clock, sync active-low reset
//        in_valid/in_ready/in_data       - plaintext handshake
//        rk_idx/round_key                - round-key request and response
//        out_valid/out_ready/out_data    - ciphertext handshake
//        busy                            - block in progress or waiting to drain
module aes_enc_ctrl
  import aes_pkg::*;
#(
  parameter int NR  = AES_NR_128,
  parameter int RKW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [127:0]   in_data,
  output logic [RKW-1:0] rk_idx,
  input  logic [127:0]   round_key,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [127:0]   out_data,
  output logic           busy
);

  localparam logic [RKW-1:0] LAST_ROUND = RKW'(NR);

  ctrl_state_e    state;
  logic [RKW-1:0] round_q;
  logic [127:0]   state_q;
  logic [127:0]   round_out;
  logic           last;

  assign last = (round_q == LAST_ROUND);

  aes_round u_round (
    .state_in  (state_q),
    .round_key (round_key),
    .last      (last),
    .state_out (round_out)
  );

  // Key 0 is needed in IDLE for the initial AddRoundKey; DONE needs no key.
  assign rk_idx   = (state == ROUND) ? round_q : '0;
  assign out_data = state_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      round_q   <= '0;
      state_q   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state_q  <= in_data ^ round_key;
            round_q  <= RKW'(1);
            state    <= ROUND;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ROUND: begin
          state_q <= round_out;
          if (last) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            round_q <= round_q + RKW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            round_q   <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          round_q   <= '0;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_enc_ctrl.sv
// tb/tb_aes_enc_ctrl.sv - self-checking bench for aes_enc_ctrl
module tb_aes_enc_ctrl;

  localparam int NR  = 10;
  localparam int RKW = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b1;
  logic [127:0]   in_data = 128'h0;
  logic           in_ready;
  logic           out_valid;
  logic           busy;
  logic [127:0]   out_data;
  logic [127:0]   round_key;
  logic [RKW-1:0] rk_idx;

  logic [127:0] rk_tab [16];
  logic [127:0] ref_rk [11];
  logic [7:0]   sb [256];
  int           trace [$];
  time          acc_time;
  int           checks = 0;
  int           failures = 0;

  always #5 clk = ~clk;

  assign round_key = rk_tab[rk_idx];

  aes_enc_ctrl #(.NR(NR), .RKW(RKW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rk_idx    (rk_idx),
    .round_key (round_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse then affine transform.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [127:0] v, input int i);
    return 8'(v >> (8 * (15 - i)));
  endfunction

  task automatic load_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = 32'(key >> (32 * (3 - i)));
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 16; k++) rk_tab[k] = 128'h0;
    for (int k = 0; k < 11; k++) begin
      ref_rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
      rk_tab[k] = ref_rk[k];
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [127:0] res;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = byte_of(pt, 4*c+r) ^ byte_of(ref_rk[0], 4*c+r);
    for (int rnd = 1; rnd <= NR; rnd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[r][c] = sb[s[r][(c+r)%4]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) begin
          if (rnd < NR)
            s[r][c] = gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c])
                    ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
          else
            s[r][c] = t[r][c];
          s[r][c] = s[r][c] ^ byte_of(ref_rk[rnd], 4*c+r);
        end
    end
    res = 128'h0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res = (res << 8) | 128'(s[r][c]);
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- handshake helpers ----------------
  // Offers a block, returns #1 after the accepting edge.
  task automatic offer(input logic [127:0] pt);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = pt;
    for (int i = 0; i < 100; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("accepted", 128'(ok), 128'd1);
    trace.delete();
    trace.push_back(int'(rk_idx));
    @(posedge clk);
    acc_time = $time;
    #1;
    in_valid = 1'b0;
  endtask

  // Counts edges until out_valid; returns #1 after the edge that raised it.
  task automatic wait_out(output int lat, output logic [127:0] ct);
    logic ok;
    ok  = 1'b0;
    lat = 0;
    ct  = 128'h0;
    for (int i = 0; i < 60; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        ct = out_data;
        break;
      end
      trace.push_back(int'(rk_idx));
      @(posedge clk);
      #1;
      lat++;
    end
    chk("out_valid_seen", 128'(ok), 128'd1);
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
    int           lat;
    logic         chk_trace;
  } vec_t;

  initial begin : main
    vec_t         vecs [3];
    int           lat;
    logic [127:0] ct, exp, d0, pta, ptb;
    time          t_a, t_prev;
    logic         seen;

    vecs[0].key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    vecs[0].pt  = 128'h3243f6a8885a308d313198a2e0370734;
    vecs[0].ct  = 128'h3925841d02dc09fbdc118597196a0b32;
    vecs[0].lat = 10; vecs[0].chk_trace = 1'b0;
    vecs[1].key = 128'h000102030405060708090a0b0c0d0e0f;
    vecs[1].pt  = 128'h00112233445566778899aabbccddeeff;
    vecs[1].ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    vecs[1].lat = 10; vecs[1].chk_trace = 1'b1;
    vecs[2].key = 128'h0;
    vecs[2].pt  = 128'h0;
    vecs[2].ct  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    vecs[2].lat = 10; vecs[2].chk_trace = 1'b0;

    build_sbox();
    load_key(128'h0);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_rk_idx", 128'(rk_idx), 128'd0);
    chk("rst_out_data", out_data, 128'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Known-answer vectors
    for (int v = 0; v < 3; v++) begin
      load_key(vecs[v].key);
      offer(vecs[v].pt);
      wait_out(lat, ct);
      chk($sformatf("kat%0d_ct", v), ct, vecs[v].ct);
      chk($sformatf("kat%0d_latency", v), 128'(lat), 128'(vecs[v].lat));
      if (vecs[v].chk_trace) begin
        chk("rk_trace_len", 128'(trace.size()), 128'd11);
        for (int k = 0; k < trace.size(); k++)
          chk($sformatf("rk_trace[%0d]", k), 128'(trace[k]), 128'(k));
      end
      @(posedge clk); #1;
      chk($sformatf("kat%0d_out_valid_drop", v), 128'(out_valid), 128'd0);
      chk($sformatf("kat%0d_idle_ready", v), 128'(in_ready), 128'd1);
      @(negedge clk);
    end

    // Backpressure
    out_ready = 1'b0;
    pta = rand128();
    exp = aes_ref(pta);
    offer(pta);
    wait_out(lat, ct);
    chk("bp_ct", ct, exp);
    d0 = out_data;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold_valid[%0d]", i), 128'(out_valid), 128'd1);
      chk($sformatf("bp_hold_data[%0d]", i), out_data, d0);
      chk($sformatf("bp_hold_ready[%0d]", i), 128'(in_ready), 128'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 128'(out_valid), 128'd0);
    chk("bp_release_ready", 128'(in_ready), 128'd1);
    chk("bp_release_busy", 128'(busy), 128'd0);
    @(negedge clk);

    // Busy rejection: second block held on in_valid during ROUND
    load_key(rand128());
    pta = rand128();
    ptb = rand128();
    offer(pta);
    t_a = acc_time;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = ptb;
    @(posedge clk); #1;
    chk("busy_in_ready", 128'(in_ready), 128'd0);
    chk("busy_flag", 128'(busy), 128'd1);
    wait_out(lat, ct);
    chk("busy_first_ct", ct, aes_ref(pta));
    offer(ptb);
    chk("busy_second_accept_gap", 128'((acc_time - t_a) / 10), 128'd12);
    wait_out(lat, ct);
    chk("busy_second_ct", ct, aes_ref(ptb));
    @(negedge clk);

    // Reset while round_q == 5
    offer(rand128());
    repeat (4) @(posedge clk);
    #1;
    chk("pre_reset_rk_idx", 128'(rk_idx), 128'd5);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_in_ready", 128'(in_ready), 128'd1);
    chk("midrst_out_valid", 128'(out_valid), 128'd0);
    chk("midrst_busy", 128'(busy), 128'd0);
    chk("midrst_rk_idx", 128'(rk_idx), 128'd0);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("midrst_no_output", 128'(seen), 128'd0);

    // Back-to-back random blocks, fresh key each
    t_prev = 0;
    for (int b = 0; b < 8; b++) begin
      load_key(rand128());
      pta = rand128();
      exp = aes_ref(pta);
      offer(pta);
      if (b > 0)
        chk($sformatf("b2b_ii[%0d]", b), 128'((acc_time - t_prev) / 10), 128'd12);
      t_prev = acc_time;
      wait_out(lat, ct);
      chk($sformatf("b2b_ct[%0d]", b), ct, exp);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_enc_ctrl.md
Name: aes_enc_ctrl

Overview:
Iterative AES-128 encryption controller. It owns the 128-bit state register and round counter. Each cycle it steps one round through a combinational round datapath: SubBytes -> ShiftRows -> MixColumns -> AddRoundKey, with MixColumns bypassed in the final round. Round keys come from an external key-expansion store, indexed by the rk_idx output. It sits between the block-input valid/ready interface and the ciphertext output interface of the encryption core.

Parameters:
NR, 10, number of rounds (10 for AES-128; 12/14 legal for a future key-length extension)
RKW, 4, width of rk_idx; must satisfy 2**RKW > NR

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  plaintext block offered
in_ready  out  1  controller can accept a block
in_data  in  128  plaintext; [127:120] is state byte s0, column-major per FIPS-197
rk_idx  out  RKW  round-key index requested this cycle
round_key  in  128  round key for rk_idx, valid combinationally in the same cycle
out_valid  out  1  ciphertext available
out_ready  in  1  downstream accepts ciphertext
out_data  out  128  ciphertext, same byte order as in_data
busy  out  1  high in ROUND or DONE

Behaviour:
- Reset applies when rst_n is sampled low at a rising clk edge; it is synchronous only. On reset:
  - state = IDLE, round_q = 0, state_q = 0
  - in_ready = 1, out_valid = 0, busy = 0, rk_idx = 0, out_data = 0
- Reset mid-operation discards the block in progress. No out_valid is produced for it.
- FSM states are IDLE, ROUND and DONE.
- IDLE:
  - in_ready = 1, rk_idx = 0.
  - On in_valid at an edge: state_q <= in_data ^ round_key (initial AddRoundKey), round_q <= 1, next state ROUND.
- ROUND:
  - in_ready = 0, rk_idx = round_q.
  - Each edge: state_q <= round_fn(state_q, round_key, last = (round_q == NR)).
  - If round_q == NR, next state is DONE. Otherwise round_q <= round_q + 1.
- DONE:
  - out_valid = 1, out_data = state_q, in_ready = 0, rk_idx = 0.
  - On out_ready at an edge: next state is IDLE and out_valid drops the following cycle.
  - Same-cycle re-accept is not supported; in_ready asserts only in IDLE.
- Latency: an acceptance edge at T gives out_valid high from the cycle after edge T+NR, i.e. NR cycles after the accept edge. Minimum initiation interval is NR+2 cycles.
- Backpressure: while out_valid = 1 and out_ready = 0, out_data and out_valid hold stable indefinitely.
- in_valid while not in IDLE is ignored. The upstream source must hold in_valid/in_data until it sees in_ready.
- out_data is driven directly from state_q. In states other than DONE its value is don't-care to the consumer, but it must not be X after reset.
- rk_idx is combinational from the state and round_q. The sequence seen per block is 0, 1, ..., NR.
- All byte permutation and arithmetic is modulo 2^8 / GF(2^8) with polynomial 0x11B. No width growth.

Decomposition:
- Package aes_pkg holds:
  - typedef aes_state_t = logic [127:0]
  - typedef aes_byte_t = logic [7:0]
  - localparam AES_NR_128 = 10
  - the FSM enum ctrl_state_e {IDLE, ROUND, DONE}
  - the S-box table function
  - xtime (GF multiply-by-2) function
- One sub-module, aes_round: purely combinational, ports state_in, round_key, last, state_out.
  - Internally it reuses the existing shiftrows module.
  - It adds a SubBytes stage, MixColumns gated by !last, and a final XOR with round_key.
- The controller holds all sequential logic.

Test Plan:
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734. Bench key-expansion model drives round_key from rk_idx. Required: out_data = 3925841d02dc09fbdc118597196a0b32, with out_valid exactly 10 cycles after the accept edge.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> out_data = 69c4e0d86a7b0430d8cdb78070b4c55a. The rk_idx trace must be 0, 1, 2, ..., 10.
- Backpressure: hold out_ready = 0 for 5 cycles after out_valid. Required: out_data and out_valid stable for all 5 cycles; in_ready = 0 throughout; IDLE one cycle after out_ready = 1.
- Busy rejection: hold in_valid = 1 with a second block during ROUND. Required: no acceptance until IDLE. The second block then completes with its correct ciphertext, and the first block's output is unaffected.
- Reset mid-op: drive rst_n = 0 for one edge while round_q = 5. Required: next cycle state = IDLE, in_ready = 1, out_valid = 0, busy = 0, and no ciphertext is ever emitted for the aborted block.
- Back-to-back: 8 random blocks checked against the reference model, with out_ready always 1. Required: all 8 match, with an initiation interval of exactly 12 cycles.
